// File: rtl/fifo_pkg.sv
// Shared FIFO constants and drain-side types.
// Imported by piso_shift16 and fifo_serial_drain.
package fifo_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY
  } drain_state_t;
endpackage

// File: rtl/piso_shift16.sv
// Parallel-load, MSB-first shift register with a down-counting bit index.
// Load wins over shift; cnt_zero flags the final data bit.
module piso_shift16
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             cnt_zero
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= CW'(WIDTH - 1);
    end else if (shift) begin
      shreg   <= {shreg[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign dout     = shreg[WIDTH-1];
  assign cnt_zero = (bit_cnt == '0);
endmodule

// File: rtl/fifo_serial_drain.sv
// Pops FWFT FIFO words and serialises them MSB-first over valid/ready.
// Optional even-parity trailer bit: define FIFO_DRAIN_PARITY_EN.
module fifo_serial_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_read_en,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);
  drain_state_t state;

  logic hs;
  logic last_hs;
  logic frame_done;
  logic shift;
  logic dout;
  logic cnt_zero;

  assign ser_valid = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign hs        = ser_valid && ser_ready;
  assign last_hs   = (state == ST_SHIFT) && hs && cnt_zero;
  assign shift     = (state == ST_SHIFT) && hs && !cnt_zero;

`ifdef FIFO_DRAIN_PARITY_EN
  logic parity;

  assign frame_done = (state == ST_PARITY) && hs;
  assign ser_last   = (state == ST_PARITY);
  assign ser_data   = (state == ST_PARITY) ? parity
                    : (ser_valid && dout);

  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (fifo_read_en) begin
      parity <= ^fifo_read_data;
    end
  end
`else
  assign frame_done = last_hs;
  assign ser_last   = (state == ST_SHIFT) && cnt_zero;
  assign ser_data   = ser_valid && dout;
`endif

  // Reload on the completing handshake so words run back-to-back.
  assign fifo_read_en = !fifo_empty &&
                        ((state == ST_IDLE) || frame_done);

  piso_shift16 #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (fifo_read_en),
    .shift    (shift),
    .din      (fifo_read_data),
    .dout     (dout),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_count <= '0;
    end else begin
      if (frame_done) begin
        word_count <= word_count + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
`ifdef FIFO_DRAIN_PARITY_EN
          if (last_hs) state <= ST_PARITY;
`else
          if (frame_done)
            state <= fifo_empty ? ST_IDLE : ST_SHIFT;
`endif
        end
        ST_PARITY: begin
`ifdef FIFO_DRAIN_PARITY_EN
          if (frame_done)
            state <= fifo_empty ? ST_IDLE : ST_SHIFT;
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/fifo_serial_drain.md
Name: fifo_serial_drain

Overview:
- Downstream consumer of the 16x8 first-word-fall-through (FWFT) FIFO.
- Pops one 16-bit word whenever the FIFO is non-empty and shifts it out MSB-first on a 1-bit serial link with a valid/ready handshake.
- Supports back-to-back words with no idle bit between them.
- Maintains a running count of completed words for status and debug.

Parameters:
- WIDTH, 16, word width; must match the FIFO data width.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_data  input  WIDTH  FIFO FWFT head word; valid whenever fifo_empty=0.
- fifo_read_en  output  1  FIFO pop strobe; combinational.
- ser_data  output  1  serial bit.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  sink accepts the bit on this edge when ser_valid=1.
- ser_last  output  1  marks the final bit of a word frame.
- busy  output  1  a word is in flight (state is not IDLE).
- word_count  output  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

Behaviour:
Reset:
- Reset is synchronous and active-high: rst=1 at a rising clk edge puts the block in IDLE.
- On reset: shreg=0, bit_cnt=0, word_count=0.
- After reset all outputs are 0: ser_valid, ser_data, ser_last, busy, fifo_read_en.

Interface rules:
- fifo_read_en is never asserted while fifo_empty=1.
- fifo_read_en is asserted for at most one cycle per word.
- The word is captured from fifo_read_data on the same edge that fifo_read_en pops it.

States:
- IDLE:
  - ser_valid=0.
  - If fifo_empty=0: fifo_read_en=1, shreg<=fifo_read_data, bit_cnt<=WIDTH-1, go to SHIFT.
  - Latency: first bit is valid 1 cycle after fifo_empty falls.
- SHIFT:
  - ser_valid=1, ser_data=shreg[WIDTH-1], ser_last=(bit_cnt==0).
  - On handshake (ser_valid && ser_ready) with bit_cnt>0: shreg<<=1, bit_cnt--.
  - On handshake with bit_cnt==0, the frame is complete: word_count++.
    - If fifo_empty=0: pop and reload in the same cycle (fifo_read_en=1), stay in SHIFT. No bubble between words.
    - Otherwise: go to IDLE.
- Stall: when ser_valid=1 and ser_ready=0, ser_data, ser_last, shreg and bit_cnt all hold.

Boundary conditions:
- ser_ready=1 continuously with FIFO always non-empty: exactly WIDTH bits per word, a new word every WIDTH cycles.
- FIFO becomes empty exactly at the last bit: return to IDLE, ser_valid=0 on the next cycle.
- ser_ready toggles on the last bit: the frame completes only on the cycle where ser_ready=1.
- word_count at 2^CNT_W-1 increments to 0.
- rst mid-frame:
  - The word is abandoned; its popped FIFO entry is lost. This is by design; upstream is reset together with this block.
  - ser_valid drops on the cycle after rst is sampled.
- ser_ready is ignored while in IDLE.

Optional Feature:
Macro: FIFO_DRAIN_PARITY_EN
- Defined:
  - At load, parity<=^fifo_read_data (even parity).
  - After the data bit with bit_cnt==0 handshakes, enter state PARITY: ser_data=parity, ser_valid=1, ser_last=1.
  - ser_last is 0 on data bits.
  - The frame completes, word_count increments, and the back-to-back reload check applies on the PARITY handshake.
  - Frame length is WIDTH+1 bits.
- Undefined:
  - No PARITY state and no parity register.
  - Frame length is WIDTH bits.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_WIDTH=16, FIFO_DEPTH=8 constants.
  - typedef logic [FIFO_WIDTH-1:0] word_t.
  - typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} drain_state_t.
- Sub-module: piso_shift16.
  - Parallel-load, shift-enable, MSB-out register with bit counter.
  - Ports: load, shift, din, dout, cnt_zero.
  - The FSM and word counter stay in fifo_serial_drain.

Test Plan:
- Reset then idle: fifo_empty=1 for 10 cycles -> fifo_read_en=0, ser_valid=0, busy=0, word_count=0 throughout.
- Single word 16'hA5C3, ser_ready=1:
  - fifo_read_en pulses 1 cycle.
  - ser_data sequence 1010010111000011 over 16 cycles; ser_last on bit 16.
  - word_count=1, then IDLE.
- Back-to-back 16'hFFFF then 16'h0001, ser_ready=1:
  - 32 consecutive valid cycles with no gap.
  - Second fifo_read_en coincides with the first word's last-bit handshake.
  - word_count=2.
- Backpressure: word 16'h8000, ser_ready=0 for cycles 3-7 of the frame -> ser_data/ser_last stable while stalled; frame completes in 21 cycles.
- rst=1 asserted at bit 5 of 16'h1234 -> ser_valid=0 and word_count=0 on the next cycle, then the next FIFO word is popped normally.
- With FIFO_DRAIN_PARITY_EN: word 16'h0007 -> 16 data bits then parity bit 1 with ser_last=1; word 16'h0003 -> parity bit 0.
